// File: rtl/nonogram_pkg.sv
// Shared types and sizes for the nonogram option feeder.
// Optional feature macro: FEEDER_STALL_DETECT_EN.
package nonogram_pkg;

  localparam int SIZE   = 11;
  localparam int OPT_W  = 11;
  localparam int CNT_W  = 7;
  localparam int LINE_W = 5;
  localparam int DEPTH  = 128;
  localparam int NLINES = 2 * SIZE;
  // Total must reach DEPTH when the FIFO is full.
  localparam int TOT_W  = $clog2(DEPTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_IDX,
    S_OPT,
    S_GAP,
    S_CHECK,
    S_DONE
  } feeder_state_t;

  typedef logic [LINE_W-1:0] line_idx_t;

endpackage

// File: rtl/option_fifo.sv
// Circular option FIFO; pop and push in one cycle are allowed,
// and a pop frees the slot for a same-cycle push when full.
module option_fifo #(
  parameter int DEPTH = 128,
  parameter int W     = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, wr_d;
  logic [AW:0]  rd_q, rd_d;
  logic         do_pop;
  logic         do_push;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign rdata_o = mem_q[rd_q[AW-1:0]];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + (AW+1)'(1);
    if (do_pop)  rd_d = rd_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/option_feeder.sv
// Replays buffered line options to the solver round after round.
// Define FEEDER_STALL_DETECT_EN to stop when a round makes no progress.
module option_feeder
  import nonogram_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic [3:0]                   num_rows,
  input  logic [3:0]                   num_cols,
  input  logic                         ld_valid,
  output logic                         ld_ready,
  input  logic [OPT_W-1:0]             ld_option,
  input  logic [LINE_W-1:0]            ld_line,
  input  logic                         ld_done,
  input  logic                         start,
  input  logic                         solved,
  input  logic                         unsolvable,
  input  logic                         put_back_to_FIFO,
  output logic [OPT_W-1:0]             option,
  output logic                         new_line,
  output logic                         opt_valid,
  output logic [NLINES-1:0][CNT_W-1:0] old_options_amnt,
  output logic [TOT_W-1:0]             all_options_remaining,
  output logic [7:0]                   round_cnt,
  output logic                         busy,
  output logic                         done,
  output logic                         overflow,
  output logic                         stalled
);

  feeder_state_t               state_q, state_d;
  line_idx_t                   line_q, line_d;
  line_idx_t                   last_line;
  logic [CNT_W-1:0]            left_q, left_d;
  logic [CNT_W-1:0]            kept_q, kept_d;
  logic [OPT_W-1:0]            last_q, last_d;
  logic [NLINES-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [TOT_W-1:0]            total_q, total_d;
  logic [7:0]                  round_q, round_d;
  logic                        ovf_q, ovf_d;
  logic                        ldd_q, ldd_d;
  logic                        stop_q, stop_d;
  logic                        stall_hit;

  logic                        f_push, f_pop;
  logic [OPT_W-1:0]            f_wdata, f_rdata;
  logic                        f_full, f_empty;

  option_fifo #(
    .DEPTH (DEPTH),
    .W     (OPT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (f_push),
    .pop_i   (f_pop),
    .wdata_i (f_wdata),
    .rdata_o (f_rdata),
    .full_o  (f_full),
    .empty_o (f_empty)
  );

  assign last_line = line_idx_t'({1'b0, num_rows} + {1'b0, num_cols})
                     - line_idx_t'(1);

  assign old_options_amnt      = cnt_q;
  assign all_options_remaining = total_q;
  assign round_cnt             = round_q;
  assign overflow              = ovf_q;
  assign done                  = (state_q == S_DONE);
  assign busy = (state_q == S_IDX) || (state_q == S_OPT) ||
                (state_q == S_GAP) || (state_q == S_CHECK);

`ifdef FEEDER_STALL_DETECT_EN
  logic [TOT_W-1:0] start_tot_q;
  logic             stall_q;

  assign stall_hit = (total_q == start_tot_q);
  assign stalled   = stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_tot_q <= '0;
      stall_q     <= 1'b0;
    end else begin
      if (state_q == S_IDX && line_q == '0)
        start_tot_q <= total_q;
      if (state_q == S_CHECK && total_q != '0 && stall_hit)
        stall_q <= 1'b1;
    end
  end
`else
  assign stall_hit = 1'b0;
  assign stalled   = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    left_d    = left_q;
    kept_d    = kept_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    total_d   = total_q;
    round_d   = round_q;
    ovf_d     = ovf_q;
    ldd_d     = ldd_q;
    f_push    = 1'b0;
    f_pop     = 1'b0;
    f_wdata   = ld_option;
    ld_ready  = 1'b0;
    new_line  = 1'b0;
    opt_valid = 1'b0;
    option    = '0;
    stop_d    = stop_q;
    if (busy && state_q != S_CHECK && (solved || unsolvable))
      stop_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (ld_valid) state_d = S_LOAD;
      end
      S_LOAD: begin
        ld_ready = !f_full;
        if (ld_valid) begin
          if (f_full) begin
            ovf_d = 1'b1;
          end else begin
            f_push = 1'b1;
            if (ld_line < LINE_W'(NLINES))
              cnt_d[ld_line] = cnt_q[ld_line] + CNT_W'(1);
            total_d = total_q + TOT_W'(1);
          end
        end
        if (ld_done) ldd_d = 1'b1;
        if (start && ldd_q) begin
          state_d = S_IDX;
          line_d  = '0;
        end
      end
      S_IDX: begin
        new_line = 1'b1;
        option   = OPT_W'(line_q);
        last_d   = OPT_W'(line_q);
        kept_d   = '0;
        left_d   = cnt_q[line_q];
        if (cnt_q[line_q] == '0 || f_empty) state_d = S_GAP;
        else                                state_d = S_OPT;
      end
      S_OPT: begin
        opt_valid = 1'b1;
        option    = f_rdata;
        last_d    = f_rdata;
        f_pop     = 1'b1;
        if (put_back_to_FIFO) begin
          f_push  = 1'b1;
          f_wdata = f_rdata;
          kept_d  = kept_q + CNT_W'(1);
        end else begin
          total_d = total_q - TOT_W'(1);
        end
        left_d = left_q - CNT_W'(1);
        if (left_q <= CNT_W'(1)) state_d = S_GAP;
      end
      S_GAP: begin
        option         = last_q;
        cnt_d[line_q]  = kept_q;
        if (stop_d) begin
          state_d = S_DONE;
        end else if (line_q == last_line) begin
          state_d = S_CHECK;
        end else begin
          line_d  = line_q + line_idx_t'(1);
          state_d = S_IDX;
        end
      end
      S_CHECK: begin
        option = last_q;
        if (round_q != 8'hFF) round_d = round_q + 8'd1;
        if (total_q == '0 || stall_hit) begin
          state_d = S_DONE;
        end else begin
          line_d  = '0;
          state_d = S_IDX;
        end
      end
      S_DONE: begin
        option = last_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      line_q  <= '0;
      left_q  <= '0;
      kept_q  <= '0;
      last_q  <= '0;
      cnt_q   <= '0;
      total_q <= '0;
      round_q <= '0;
      ovf_q   <= 1'b0;
      ldd_q   <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      left_q  <= left_d;
      kept_q  <= kept_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      total_q <= total_d;
      round_q <= round_d;
      ovf_q   <= ovf_d;
      ldd_q   <= ldd_d;
      stop_q  <= stop_d;
    end
  end

endmodule

// File: tb/tb_option_feeder.sv
// Directed bench for option_feeder: load, replay rounds,
// drop/keep, early stop, stall/repeat, overflow, async reset.
module tb_option_feeder;
  import nonogram_pkg::*;

  logic                         clk = 1'b0;
  logic                         rst = 1'b0;
  logic [3:0]                   num_rows = 4'd4;
  logic [3:0]                   num_cols = 4'd4;
  logic                         ld_valid = 1'b0;
  logic                         ld_ready;
  logic [OPT_W-1:0]             ld_option = '0;
  logic [LINE_W-1:0]            ld_line = '0;
  logic                         ld_done = 1'b0;
  logic                         start = 1'b0;
  logic                         solved = 1'b0;
  logic                         unsolvable = 1'b0;
  logic                         put_back = 1'b1;
  logic [OPT_W-1:0]             option;
  logic                         new_line;
  logic                         opt_valid;
  logic [NLINES-1:0][CNT_W-1:0] old_amnt;
  logic [TOT_W-1:0]             total;
  logic [7:0]                   round_cnt;
  logic                         busy;
  logic                         done;
  logic                         overflow;
  logic                         stalled;

  int n_chk = 0;
  int n_err = 0;

  int init_cnt [8] = '{3, 3, 3, 1, 2, 4, 1, 3};
  int init_opt [8][4] = '{
    '{'h3, 'h6, 'hC, 0},
    '{'h5, 'hA, 'h9, 0},
    '{'h7, 'hE, 'hB, 0},
    '{'hD, 0, 0, 0},
    '{'h1, 'h8, 0, 0},
    '{'h3, 'h5, 'h9, 'h6},
    '{'hF, 0, 0, 0},
    '{'h2, 'h4, 'h8, 0}
  };
  int m_cnt [8];
  int m_opt [8][4];

  option_feeder dut (
    .clk                   (clk),
    .rst                   (rst),
    .num_rows              (num_rows),
    .num_cols              (num_cols),
    .ld_valid              (ld_valid),
    .ld_ready              (ld_ready),
    .ld_option             (ld_option),
    .ld_line               (ld_line),
    .ld_done               (ld_done),
    .start                 (start),
    .solved                (solved),
    .unsolvable            (unsolvable),
    .put_back_to_FIFO      (put_back),
    .option                (option),
    .new_line              (new_line),
    .opt_valid             (opt_valid),
    .old_options_amnt      (old_amnt),
    .all_options_remaining (total),
    .round_cnt             (round_cnt),
    .busy                  (busy),
    .done                  (done),
    .overflow              (overflow),
    .stalled               (stalled)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  task automatic push(input int ln, input int op);
    logic acc;
    int   n;
    ld_valid  = 1'b1;
    ld_line   = LINE_W'(ln);
    ld_option = OPT_W'(op);
    n = 0;
    do begin
      acc = ld_ready;
      step();
      n++;
    end while (!acc && n < 10);
    if (!acc) chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic load_and_start();
    for (int l = 0; l < 8; l++) begin
      m_cnt[l] = init_cnt[l];
      for (int k = 0; k < 4; k++) m_opt[l][k] = init_opt[l][k];
      for (int k = 0; k < init_cnt[l]; k++) push(l, init_opt[l][k]);
    end
    ld_valid = 1'b0;
    ld_done  = 1'b1;
    step();
    ld_done = 1'b0;
    start   = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Entered in IDX; leaves one step after GAP.
  task automatic do_line(input int ln, input int drop_k,
                         input int raise_k);
    int n;
    int last;
    int kept;
    chk($sformatf("idx_nl_%0d", ln), 32'(new_line), 32'd1);
    chk($sformatf("idx_opt_%0d", ln), 32'(option), 32'(ln));
    n    = m_cnt[ln];
    last = ln;
    step();
    for (int k = 0; k < n; k++) begin
      chk($sformatf("ov_%0d_%0d", ln, k), 32'(opt_valid), 32'd1);
      chk($sformatf("op_%0d_%0d", ln, k), 32'(option),
          32'(m_opt[ln][k]));
      last     = m_opt[ln][k];
      put_back = (k != drop_k);
      if (k == raise_k) unsolvable = 1'b1;
      step();
    end
    put_back = 1'b1;
    chk($sformatf("gap_opt_%0d", ln), 32'(option), 32'(last));
    chk($sformatf("gap_nl_%0d", ln), 32'(new_line), 32'd0);
    chk($sformatf("gap_ov_%0d", ln), 32'(opt_valid), 32'd0);
    kept = 0;
    for (int k = 0; k < n; k++) begin
      if (k != drop_k) begin
        m_opt[ln][kept] = m_opt[ln][k];
        kept++;
      end
    end
    m_cnt[ln] = kept;
    step();
    chk($sformatf("amnt_%0d", ln), 32'(old_amnt[ln]), 32'(kept));
  endtask

  initial begin
    #2;
    chk("rst_option", 32'(option), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_total", 32'(total), 32'd0);
    chk("rst_ldrdy", 32'(ld_ready), 32'd0);
    do_reset();

    // Scenario 1/2: first round, drop row3's only option
    load_and_start();
    chk("load_total", 32'(total), 32'd20);
    chk("load_col1", 32'(old_amnt[5]), 32'd4);
    chk("busy_r1", 32'(busy), 32'd1);
    for (int l = 0; l < 8; l++) do_line(l, (l == 3) ? 0 : -1, -1);
    chk("check_busy", 32'(busy), 32'd1);
    chk("check_rnd", 32'(round_cnt), 32'd0);
    step();
    chk("r2_rnd", 32'(round_cnt), 32'd1);
    chk("r2_total", 32'(total), 32'd19);
    chk("r2_row3", 32'(old_amnt[3]), 32'd0);

    // Scenario 3: unsolvable during col1 option 2
    for (int l = 0; l < 5; l++) do_line(l, -1, -1);
    do_line(5, -1, 1);
    chk("stop_done", 32'(done), 32'd1);
    chk("stop_busy", 32'(busy), 32'd0);
    unsolvable = 1'b0;
    step();
    step();
    chk("hold_done", 32'(done), 32'd1);
    chk("hold_opt", 32'(option), 32'h6);
    chk("hold_nl", 32'(new_line), 32'd0);
    chk("hold_rnd", 32'(round_cnt), 32'd1);

    // Scenario 4: keep everything for a full round
    do_reset();
    load_and_start();
    for (int l = 0; l < 8; l++) do_line(l, -1, -1);
    step();
    chk("keep_rnd", 32'(round_cnt), 32'd1);
    chk("keep_total", 32'(total), 32'd20);
`ifdef FEEDER_STALL_DETECT_EN
    chk("stall_flag", 32'(stalled), 32'd1);
    chk("stall_done", 32'(done), 32'd1);
`else
    chk("stall_flag", 32'(stalled), 32'd0);
    chk("rpt_nl", 32'(new_line), 32'd1);
    chk("rpt_opt", 32'(option), 32'd0);
`endif

    // Scenario 5: fill to DEPTH, then force one more beat
    do_reset();
    num_rows = 4'd8;
    num_cols = 4'd8;
    for (int i = 0; i < DEPTH; i++) push(i / 8, i);
    chk("full_ldrdy", 32'(ld_ready), 32'd0);
    chk("full_ovf0", 32'(overflow), 32'd0);
    ld_valid = 1'b1;
    step();
    ld_valid = 1'b0;
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_total", 32'(total), 32'(DEPTH));
    chk("ovf_line15", 32'(old_amnt[15]), 32'd8);

    // Scenario 6: async reset during row2 OPT
    do_reset();
    num_rows = 4'd4;
    num_cols = 4'd4;
    load_and_start();
    do_line(0, -1, -1);
    do_line(1, -1, -1);
    step();
    chk("r6_ov", 32'(opt_valid), 32'd1);
    rst = 1'b0;
    #1;
    chk("r6_opt", 32'(option), 32'd0);
    chk("r6_ov0", 32'(opt_valid), 32'd0);
    chk("r6_busy", 32'(busy), 32'd0);
    chk("r6_total", 32'(total), 32'd0);
    chk("r6_amnt0", 32'(old_amnt[0]), 32'd0);
    chk("r6_ldrdy", 32'(ld_ready), 32'd0);
    rst = 1'b1;
    step();
    chk("r6_idle", 32'(busy | done), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
